// File: rtl/timer_cmp_pkg.sv
// timer_cmp_pkg: register offsets, limits and mode encoding for the compare/interrupt block
package timer_cmp_pkg;
  localparam logic [7:0] CMP_STRIDE = 8'h08;
  localparam logic [7:0] IER_OFF = 8'h40;
  localparam logic [7:0] ISR_OFF = 8'h44;
  localparam logic [7:0] IMODE_OFF = 8'h48;
  localparam logic [7:0] MISS_OFF = 8'h4C;
  localparam int CMP_SHIFT = $clog2(CMP_STRIDE);
  localparam int MAX_CH = 8;
  localparam int MAX_CNT_W = 64;
  typedef enum logic {
    MODE_EDGE = 1'b0,
    MODE_LEVEL = 1'b1
  } imode_e;
endpackage

// File: rtl/timer_cmp_int_mc_ch.sv
// timer_cmp_ch: one compare channel with its cmp register, edge tracker and sticky ISR/MISS bits
module timer_cmp_ch
  import timer_cmp_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [CNT_W-1:0]     cnt,
  input  logic                 mode,
  input  logic                 lo_wr,
  input  logic                 hi_wr,
  input  logic [31:0]          wdata,
  input  logic                 isr_clr,
  input  logic                 miss_clr,
  output logic [MAX_CNT_W-1:0] cmp_rd,
  output logic                 isr,
  output logic                 miss
);
  logic [CNT_W-1:0] cmp;
  logic [MAX_CNT_W-1:0] cmp_wr;
  logic match_q, eq, ge, evt, set, miss_set;
  // bits of a HI write above CNT_W fall away on truncation
  always_comb begin
    cmp_rd = '0;
    cmp_rd[CNT_W-1:0] = cmp;
    cmp_wr = cmp_rd;
    if (lo_wr) cmp_wr[31:0] = wdata;
    if (hi_wr) cmp_wr[MAX_CNT_W-1:32] = wdata;
  end
  assign eq = cnt == cmp;
  assign ge = cnt >= cmp;
  assign evt = eq & ~match_q;
  assign set = (mode == MODE_LEVEL) ? ge : evt;
  assign miss_set = (mode == MODE_EDGE) & evt & isr & ~isr_clr;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmp <= '1;
      match_q <= 1'b0;
      isr <= 1'b0;
      miss <= 1'b0;
    end else begin
      if (lo_wr || hi_wr) cmp <= cmp_wr[CNT_W-1:0];
      match_q <= eq;
      isr <= set | (isr & ~isr_clr);
      miss <= miss_set | (miss & ~miss_clr);
    end
  end
endmodule

// File: rtl/timer_cmp_int_mc.sv
// timer_cmp_int_mc: multi-channel compare/interrupt controller with register access
module timer_cmp_int_mc
  import timer_cmp_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int NUM_CH = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [7:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic [NUM_CH-1:0] ch_int,
  output logic              tim_int
);
  logic [NUM_CH-1:0] ier, imode, isr_clr, miss_clr;
  logic [MAX_CH-1:0] isr, miss;
  logic [MAX_CNT_W-1:0] cmp_rd [MAX_CH];
  logic cmp_sel, hi;
  logic [2:0] ch;
  logic [31:0] rdata_nxt;
  assign cmp_sel = (reg_addr < IER_OFF) && (reg_addr[1:0] == 2'b00);
  assign ch = reg_addr[CMP_SHIFT+:3];
  assign hi = reg_addr[2];
  assign isr_clr = (reg_wr && reg_addr == ISR_OFF) ? reg_wdata[NUM_CH-1:0] : '0;
  assign miss_clr = (reg_wr && reg_addr == MISS_OFF) ? reg_wdata[NUM_CH-1:0] : '0;
  // unused channel slots read as zero so the read mux needs no range check
  for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      timer_cmp_ch #(.CNT_W(CNT_W)) u_ch (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .cnt      (cnt),
        .mode     (imode[i]),
        .lo_wr    (reg_wr & cmp_sel & (ch == 3'(i)) & ~hi),
        .hi_wr    (reg_wr & cmp_sel & (ch == 3'(i)) & hi),
        .wdata    (reg_wdata),
        .isr_clr  (isr_clr[i]),
        .miss_clr (miss_clr[i]),
        .cmp_rd   (cmp_rd[i]),
        .isr      (isr[i]),
        .miss     (miss[i])
      );
    end else begin : g_off
      assign cmp_rd[i] = '0;
      assign isr[i] = 1'b0;
      assign miss[i] = 1'b0;
    end
  end
  always_comb begin
    rdata_nxt = '0;
    if (cmp_sel) rdata_nxt = hi ? cmp_rd[ch][63:32] : cmp_rd[ch][31:0];
    else if (reg_addr == IER_OFF) rdata_nxt = 32'(ier);
    else if (reg_addr == ISR_OFF) rdata_nxt = 32'(isr);
    else if (reg_addr == IMODE_OFF) rdata_nxt = 32'(imode);
    else if (reg_addr == MISS_OFF) rdata_nxt = 32'(miss);
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ier <= '0;
      imode <= '0;
      reg_rdata <= '0;
    end else begin
      if (reg_wr && reg_addr == IER_OFF) ier <= reg_wdata[NUM_CH-1:0];
      if (reg_wr && reg_addr == IMODE_OFF) imode <= reg_wdata[NUM_CH-1:0];
      if (reg_rd) reg_rdata <= rdata_nxt;
    end
  end
  assign ch_int = isr[NUM_CH-1:0] & ier;
  assign tim_int = |ch_int;
endmodule

// File: doc/timer_cmp_int_mc.md
Name: timer_cmp_int_mc

Overview:
Parametrised multi-channel compare and interrupt controller, successor to the single-channel timer interrupt logic. Sits beside the timer counter and takes the live count as input. NUM_CH independent compare channels each carry sticky W1C status, per-channel enable, selectable edge/level match mode and a sticky missed-event flag. Outputs per-channel interrupts plus a global OR'd tim_int.

Parameters:
CNT_W, 64, counter/compare width (1..64); bits above 32 live in the HI word.
NUM_CH, 4, number of compare channels (1..8).

Ports:
sys_clk  in  1  system clock, all state on rising edge.
sys_rst_n  in  1  asynchronous active-low reset.
cnt  in  CNT_W  current counter value, synchronous to sys_clk.
reg_wr  in  1  register write strobe, one cycle per write.
reg_rd  in  1  register read strobe.
reg_addr  in  8  byte address, word aligned.
reg_wdata  in  32  write data.
reg_rdata  out  32  read data, registered.
ch_int  out  NUM_CH  per-channel interrupt, ch_int[n] = ISR[n] & IER[n].
tim_int  out  1  OR of ch_int.

Behaviour:
- Register map:
  - CMPn_LO at 0x08*n holds cmp[n][31:0].
  - CMPn_HI at 0x08*n+4 holds cmp[n][CNT_W-1:32]. It reads 0 and ignores writes when CNT_W<=32.
  - IER at 0x40 is RW.
  - ISR at 0x44 is RW1C.
  - IMODE at 0x48 is RW. 0 = edge-equal, 1 = level-greater-or-equal.
  - MISS at 0x4C is RW1C.
- Unmapped addresses and channels >= NUM_CH read 0 and ignore writes. Bits [31:NUM_CH] of IER/ISR/IMODE/MISS read 0.
- Reset values:
  - cmp = all ones.
  - IER, ISR, IMODE, MISS, match_q = 0.
  - reg_rdata = 0, ch_int = 0, tim_int = 0.
- Reads: reg_rdata updates on the edge where reg_rd=1 (latency 1) and holds otherwise. Read has no side effects.
- Writes take effect on the edge where reg_wr=1. A write to ISR/MISS clears each bit whose wdata bit is 1; a 0 in wdata leaves that bit unchanged.
- Per-channel match condition (combinational from registered cmp and the cnt input):
  - eq = (cnt == cmp).
  - ge = (cnt >= cmp), unsigned compare.
- match_q[n] registers eq every cycle.
- Edge mode (IMODE[n]=0):
  - Event = eq & ~match_q.
  - ISR[n] sets on the event edge.
  - While cnt stays equal, a W1C clear holds ISR low; there is no re-assert until eq falls and rises again.
  - Writing a CMP value equal to a static cnt gives an event one cycle after the write edge.
- Level mode (IMODE[n]=1):
  - ISR[n] sets every cycle ge=1.
  - A W1C while ge holds clears for zero visible cycles: set wins.
  - MISS is never set in level mode.
- MISS[n] sets on an edge-mode event while ISR[n] is already 1 and not being cleared that same cycle.
- Simultaneous W1C and new event in the same cycle: ISR stays 1, MISS unchanged.
- IER only gates the output. Status sets regardless of IER. Toggling IER gives an immediate ch_int change with no status change.
- Writing IMODE does not alter ISR/MISS. match_q keeps tracking eq in both modes.
- Asynchronous reset mid-operation clears all state immediately. The first event after reset requires a fresh eq rising edge.
- ch_int and tim_int are combinational from registered state only, so they are glitch-free relative to reg inputs.

Decomposition:
- Package timer_cmp_pkg holds:
  - Address offsets: CMP_STRIDE=0x08, IER_OFF=0x40, ISR_OFF=0x44, IMODE_OFF=0x48, MISS_OFF=0x4C.
  - MAX_CH=8 and MAX_CNT_W=64.
  - IMODE encoding constants.
- Sub-module timer_cmp_ch, instantiated NUM_CH times via generate. It owns cmp, match_q, the eq/ge compare, and the ISR/MISS bit update logic.
- Top level does address decode, IER/IMODE storage, the read mux and output gating.

Test Plan:
- Edge basic: CMP0=0xFF, IER=1, cnt ramps 0→0x100 → ISR=0x1, ch_int[0]=1, tim_int=1 from the cycle after cnt==0xFF; write ISR=0 → unchanged; write ISR=1 → ISR=0, tim_int=0.
- Static equal: CMP1=0x123, cnt held 0x123, IER=0x2 → ISR=0x2; W1C 0x2, wait 4 cycles → ISR=0x0 (no re-assert); cnt→0x124→0x123 → ISR=0x2.
- Level mode: IMODE=0x4, CMP2=0x10, cnt=0x20 → ISR[2]=1; W1C → still reads 1; cnt=0x0F then W1C → 0.
- Miss/simultaneous: CMP0 event, no clear, second event → MISS=0x1. Separately, W1C issued on the same edge as an event → ISR=1, MISS=0.
- Gating and width: IER=0 at event → tim_int=0, ISR=1; IER=1 → tim_int=1 next cycle. CMP3_HI=0x1, CMP3_LO=0x0, cnt=0x1_0000_0000 → ISR[3]=1. Read 0x50 → 0.
- Reset mid-operation: ISR=0xF, MISS=0x1, pulse sys_rst_n low asynchronously → all registers 0; CMPn read 0xFFFFFFFF; tim_int=0.
